// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_DEPTH       = 64;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmemState_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port and one registered read port.
// The read register is reset and clearable; the array itself is never reset.
module dmem_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  input  logic             rdClr,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrIdx] <= wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdData <= '0;
    else if (rdEn)  rdData <= mem[rdIdx];
    else if (rdClr) rdData <= '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable wait states.
// Optional misalignment rejection is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmemState_t       state, stateNext;
  logic [3:0]       waitCnt;
  logic             latWe, latErr;
  logic [IDX_W-1:0] latIdx;
  logic [WIDTH-1:0] latData;
  logic             reqErr;
  logic [IDX_W-1:0] reqIdx;
  logic             accWe, accErr;
  logic [IDX_W-1:0] accIdx;
  logic [WIDTH-1:0] accData;
  logic             accept, enterResp, leaveResp;
  logic             wrEn, rdEn, rdClr;
  logic             respErr;
  logic             unusedAddr;

  assign reqIdx     = req_addr[IDX_W+1:2];
  assign unusedAddr = ^req_addr;

`ifdef DMEM_ERR_CHECK_EN
  assign reqErr = (req_addr[1:0] != 2'b00);
`else
  assign reqErr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (req_valid) stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt == '0) stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  assign accept    = req_valid && req_ready;
  assign enterResp = (stateNext == RESP) && (state != RESP);
  assign leaveResp = (state == RESP) && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt <= '0;
      latWe   <= 1'b0;
      latErr  <= 1'b0;
      latIdx  <= '0;
      latData <= '0;
    end else if (accept) begin
      waitCnt <= CNT_INIT;
      latWe   <= req_we;
      latErr  <= reqErr;
      latIdx  <= reqIdx;
      latData <= req_wdata;
    end else if (state == WAIT && waitCnt != '0) begin
      waitCnt <= waitCnt - 4'd1;
    end
  end

  // With zero wait states RESP is entered on the accept edge itself, before
  // the request has been latched, so the access must use the live inputs.
  always_comb begin
    if (state == IDLE) begin
      accWe   = req_we;
      accErr  = reqErr;
      accIdx  = reqIdx;
      accData = req_wdata;
    end else begin
      accWe   = latWe;
      accErr  = latErr;
      accIdx  = latIdx;
      accData = latData;
    end
  end

  assign wrEn  = enterResp && accWe && !accErr && !rst;
  assign rdEn  = enterResp && !accWe && !accErr && !rst;
  assign rdClr = leaveResp || (enterResp && !rdEn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            respErr <= 1'b0;
    else if (enterResp) respErr <= accErr;
    else if (leaveResp) respErr <= 1'b0;
  end

  assign resp_err = respErr;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) uArray (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrIdx  (accIdx),
    .wrData (accData),
    .rdEn   (rdEn),
    .rdClr  (rdClr),
    .rdIdx  (accIdx),
    .rdData (resp_rdata)
  );

endmodule
